pcileech_com_rx_demux: RTL

//  Consumes the 64-bit RX word stream leaving the communication core (one word per valid cycle, no

---
 rtl/pcileech_com_pkg.sv | 38 +++
 rtl/pcileech_com_rx_tlpbuf.sv | 85 ++++++++
 rtl/pcileech_com_rx_demux.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pcileech_com_pkg.sv
// pcileech_com_pkg
//   Shared definitions for the COM RX demultiplexer: the 64-bit COM word
//   layout, the word type and demux state encodings, and a word screening
//   helper.
package pcileech_com_pkg;

  localparam logic [7:0] COM_MAGIC = 8'h77;

  typedef enum logic [1:0] {
    TLP  = 2'b00,
    RSVD = 2'b01,
    LOOP = 2'b10,
    CMD  = 2'b11
  } com_type_t;

  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] addr;
    logic [2:0]  rsvd_hi;
    logic        last;
    logic [1:0]  rsvd_lo;
    com_type_t   ctype;
    logic [7:0]  magic;
  } com_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FRAME = 2'b01,
    DROP  = 2'b10
  } demux_state_t;

  // A word is routable when the magic matches and the type is not reserved.
  // All-zero words fail the magic check and so fall out here as well.
  function automatic logic word_accepted(input com_word_t w);
    return (w.magic == COM_MAGIC) && (w.ctype != RSVD);
  endfunction

endpackage

// File: rtl/pcileech_com_rx_tlpbuf.sv
// pcileech_com_rx_tlpbuf
//   Commit/rewind dword FIFO holding {last, data}. The write side may rewind
//   its pointer to the last committed frame boundary; the read side only
//   ever sees committed (complete) frames. The read port is a registered
//   output stage that holds steady while valid & ~ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en, wr_data        write one {last, dword}
//   commit                with wr_en: this dword closes the frame
//   rewind                discard the uncommitted part of the frame
//   full                  no room for a write this cycle
//   tlp_data/last/valid   registered read output
//   tlp_ready             consumer accepts when valid & ready
module pcileech_com_rx_tlpbuf #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [32:0] wr_data,
  input  logic        commit,
  input  logic        rewind,
  output logic        full,
  output logic [31:0] tlp_data,
  output logic        tlp_last,
  output logic        tlp_valid,
  input  logic        tlp_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [32:0] mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] cmt_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        pop_s;
  logic        full_raw_s;

  // Move a committed dword into the output stage whenever it is empty or draining.
  assign pop_s      = (rd_ptr_r != cmt_ptr_r) && (!tlp_valid || tlp_ready);
  assign full_raw_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // A pop in the same cycle frees the slot being written, so a full buffer still accepts.
  assign full       = full_raw_s && !pop_s;

  // Dword storage; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Write and committed pointers; rewind snaps back to the last frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      cmt_ptr_r <= '0;
    end else if (rewind) begin
      wr_ptr_r <= cmt_ptr_r;
    end else if (wr_en) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (commit) begin
        cmt_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Read pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r  <= '0;
      tlp_valid <= 1'b0;
      tlp_data  <= 32'h0000_0000;
      tlp_last  <= 1'b0;
    end else if (pop_s) begin
      rd_ptr_r               <= rd_ptr_r + PTR_ONE;
      tlp_valid              <= 1'b1;
      {tlp_last, tlp_data}   <= mem_r[rd_ptr_r[AW-1:0]];
    end else if (tlp_ready) begin
      tlp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pcileech_com_rx_demux.sv
// pcileech_com_rx_demux
//   Splits the 64-bit COM RX word stream (no backpressure) into a framed
//   TLP dword stream, register-write strobes and loopback dwords. Words with
//   a bad magic or the reserved type are dropped. TLP frames are buffered and
//   released only once complete; frames that overflow the buffer or exceed
//   TLP_MAX_DW dwords are dropped and flagged on the sticky err_drop.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rx_data, rx_valid              incoming COM words
//   tlp_data/valid/last, tlp_ready framed TLP output
//   cmd_addr, cmd_data, cmd_wr     register write strobe (one cycle)
//   lb_data, lb_wr_en, lb_ready    loopback toward COM TX (best effort)
//   err_drop                       sticky frame-drop flag
// Build option:
//   COM_RX_DEMUX_STATS_EN adds saturating counters stat_words (every valid
//   word) and stat_bad (magic/type drops).
module pcileech_com_rx_demux
  import pcileech_com_pkg::*;
#(
  parameter int TLP_FIFO_DEPTH = 64,
  parameter int TLP_MAX_DW     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic [31:0] tlp_data,
  output logic        tlp_valid,
  output logic        tlp_last,
  input  logic        tlp_ready,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_wr,
  output logic [31:0] lb_data,
  output logic        lb_wr_en,
  input  logic        lb_ready,
  output logic        err_drop
`ifdef COM_RX_DEMUX_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [15:0] stat_bad
`endif
);

  localparam logic [10:0] MAX_DW = 11'(TLP_MAX_DW);

  com_word_t    word_s;
  logic         good_s;
  logic         tlp_in_s;
  demux_state_t state_r;
  logic [10:0]  dw_cnt_r;
  logic         buf_full_s;
  logic         buf_wr_s;
  logic         buf_commit_s;
  logic         buf_rewind_s;
  logic         overflow_s;
  logic         unused_s;

  assign word_s   = com_word_t'(rx_data);
  assign good_s   = rx_valid && word_accepted(word_s);
  assign tlp_in_s = good_s && (word_s.ctype == TLP);
  assign unused_s = ^{word_s.rsvd_hi, word_s.rsvd_lo};

  // Decide what the current TLP word does to the buffer.
  always_comb begin
    buf_wr_s     = 1'b0;
    buf_commit_s = 1'b0;
    buf_rewind_s = 1'b0;
    overflow_s   = 1'b0;
    if (tlp_in_s) begin
      case (state_r)
        IDLE: begin
          // Nothing uncommitted yet, so no rewind is needed on overflow.
          if (buf_full_s) begin
            overflow_s = 1'b1;
          end else begin
            buf_wr_s     = 1'b1;
            buf_commit_s = word_s.last;
          end
        end
        FRAME: begin
          if (buf_full_s || (dw_cnt_r >= MAX_DW)) begin
            overflow_s   = 1'b1;
            buf_rewind_s = 1'b1;
          end else begin
            buf_wr_s     = 1'b1;
            buf_commit_s = word_s.last;
          end
        end
        DROP: begin
          buf_wr_s = 1'b0;
        end
        default: begin
          buf_wr_s = 1'b0;
        end
      endcase
    end else begin
      buf_wr_s = 1'b0;
    end
  end

  // TLP framing FSM with dword counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      dw_cnt_r <= 11'd0;
      err_drop <= 1'b0;
    end else if (tlp_in_s) begin
      if (overflow_s) begin
        err_drop <= 1'b1;
        state_r  <= word_s.last ? IDLE : DROP;
      end else begin
        case (state_r)
          IDLE: begin
            dw_cnt_r <= 11'd1;
            state_r  <= word_s.last ? IDLE : FRAME;
          end
          FRAME: begin
            dw_cnt_r <= dw_cnt_r + 11'd1;
            state_r  <= word_s.last ? IDLE : FRAME;
          end
          DROP: begin
            state_r <= word_s.last ? IDLE : DROP;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  // Register-write strobe path.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr   <= 1'b0;
      cmd_addr <= 16'h0000;
      cmd_data <= 32'h0000_0000;
    end else begin
      cmd_wr <= good_s && (word_s.ctype == CMD);
      if (good_s && (word_s.ctype == CMD)) begin
        cmd_addr <= word_s.addr;
        cmd_data <= word_s.payload;
      end
    end
  end

  // Loopback path; words arriving while COM TX is almost full are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_wr_en <= 1'b0;
      lb_data  <= 32'h0000_0000;
    end else begin
      lb_wr_en <= good_s && (word_s.ctype == LOOP) && lb_ready;
      if (good_s && (word_s.ctype == LOOP) && lb_ready) begin
        lb_data <= word_s.payload;
      end
    end
  end

`ifdef COM_RX_DEMUX_STATS_EN
  // Saturating word and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words <= 32'h0000_0000;
      stat_bad   <= 16'h0000;
    end else if (rx_valid) begin
      if (stat_words != 32'hFFFF_FFFF) begin
        stat_words <= stat_words + 32'h0000_0001;
      end
      if (!word_accepted(word_s) && (stat_bad != 16'hFFFF)) begin
        stat_bad <= stat_bad + 16'h0001;
      end
    end
  end
`endif

  pcileech_com_rx_tlpbuf #(
    .DEPTH(TLP_FIFO_DEPTH)
  ) u_tlpbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_wr_s),
    .wr_data   ({word_s.last, word_s.payload}),
    .commit    (buf_commit_s),
    .rewind    (buf_rewind_s),
    .full      (buf_full_s),
    .tlp_data  (tlp_data),
    .tlp_last  (tlp_last),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready)
  );

endmodule
